// File: rtl/bcd_counter_until_19.sv
// bcd_counter_until_19
// Two-digit BCD counter over 00..19. It has a programmable prescaler, counts
// up or down, supports a synchronous load and clamps loaded units above 9.
// Vs is a one-cycle strobe that marks each new displayed value.
// carry is a one-cycle pulse on wrap (19->00 going up, 00->19 going down).
// Optional build macro: SATURATE_EN. When it is defined, the count holds at
// 19 going up and at 00 going down, and no Vs or carry is issued on a held tick.
module bcd_counter_until_19 #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_units,
  input  logic       load_tens,
  output logic [3:0] bcd_units,
  output logic [3:0] bcd_tens,
  output logic       Vs,
  output logic       carry
);

  // Terminal prescaler count; a step tick fires on the enabled cycle that reaches it.
  localparam logic [7:0] PRESCALE_MAX = 8'(PRESCALE - 1);

  logic [7:0] presc_reg, presc_next;
  logic [3:0] units_reg, units_next;
  logic       tens_reg, tens_next;
  logic       vs_reg, vs_next;
  logic       carry_reg, carry_next;
  logic       count_en;
  logic       tick;
  logic [3:0] load_units_clamped;

  // A load overrides counting, so the prescaler only advances with en high and load low.
  always_comb begin
    count_en           = en & ~load;
    tick               = count_en && (presc_reg == PRESCALE_MAX);
    load_units_clamped = (load_units > 4'd9) ? 4'd9 : load_units;
  end

  // Prescaler next state: cleared by load, held while en is low, wraps on tick.
  always_comb begin
    presc_next = presc_reg;
    if (load) begin
      presc_next = 8'd0;
    end else if (en) begin
      presc_next = tick ? 8'd0 : presc_reg + 8'd1;
    end
  end

  // BCD value next state; carry is raised only by a wrapping step, never by a load.
  always_comb begin
    units_next = units_reg;
    tens_next  = tens_reg;
    carry_next = 1'b0;
    if (load) begin
      units_next = load_units_clamped;
      tens_next  = load_tens;
    end else if (tick) begin
      if (up) begin
        if (units_reg == 4'd9 && tens_reg) begin
`ifdef SATURATE_EN
          units_next = units_reg;
          tens_next  = tens_reg;
`else
          units_next = 4'd0;
          tens_next  = 1'b0;
          carry_next = 1'b1;
`endif
        end else if (units_reg == 4'd9) begin
          units_next = 4'd0;
          tens_next  = 1'b1;
        end else begin
          units_next = units_reg + 4'd1;
        end
      end else begin
        if (units_reg == 4'd0 && !tens_reg) begin
`ifdef SATURATE_EN
          units_next = units_reg;
          tens_next  = tens_reg;
`else
          units_next = 4'd9;
          tens_next  = 1'b1;
          carry_next = 1'b1;
`endif
        end else if (units_reg == 4'd0) begin
          units_next = 4'd9;
          tens_next  = 1'b0;
        end else begin
          units_next = units_reg - 4'd1;
        end
      end
    end
  end

  // Vs marks a real change of the displayed value, so loading an identical value or a held saturating tick stays silent.
  always_comb begin
    vs_next = (units_next != units_reg) || (tens_next != tens_reg);
  end

  // State register; reset beats load and en and leaves both strobes low.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= 8'd0;
      units_reg <= 4'd0;
      tens_reg  <= 1'b0;
      vs_reg    <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      units_reg <= units_next;
      tens_reg  <= tens_next;
      vs_reg    <= vs_next;
      carry_reg <= carry_next;
    end
  end

  assign bcd_units   = units_reg;
  assign bcd_tens[0] = tens_reg;
  assign Vs          = vs_reg;
  assign carry       = carry_reg;

  // The tens digit only ever holds 0 or 1, so its upper bits are tied low.
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_tens_hi
      assign bcd_tens[gi] = 1'b0;
    end
  endgenerate

endmodule

// File: doc/bcd_counter_until_19.md
BCD_COUNTER_UNTIL_19 -- requirements
Module: bcd_counter_until_19

Interface
REQ-001 Parameter: PRESCALE, default 4, number of enabled clock cycles per count step (legal range 1..255).
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: en  input  1  count enable; when low, the prescaler and count hold.
REQ-005 Port: up  input  1  direction; 1 counts up, 0 counts down; sampled at each step.
REQ-006 Port: load  input  1  synchronous load strobe.
REQ-007 Port: load_units  input  4  BCD units value for load.
REQ-008 Port: load_tens  input  1  tens value for load (0 or 1).
REQ-009 Port: bcd_units  output  4  registered units digit, 0..9.
REQ-010 Port: bcd_tens  output  4  registered tens digit, 0 or 1; bits [3:1] always 0.
REQ-011 Port: Vs  output  1  one-cycle strobe marking a new displayed value, for the downstream 7-segment encoders.
REQ-012 Port: carry  output  1  one-cycle pulse on wrap (19->00 up, 00->19 down).

Function
REQ-013 The block shall count a two-digit BCD value over 00..19 and drive the units and tens digit encoders directly.
REQ-014 The prescaler shall increment on each cycle with en=1 and load=0, and shall generate a step tick on the cycle it equals PRESCALE-1, then return to 0.
REQ-015 On a step tick with up=1: units 0..8 -> +1; units 9 -> units 0, tens +1; value 19 -> 00 with carry=1.
REQ-016 On a step tick with up=0: units 1..9 -> -1; units 0 with tens 1 -> 09; value 00 -> 19 with carry=1.
REQ-017 The new value shall appear on bcd_units/bcd_tens in the cycle after the tick cycle, so latency is one clock.
REQ-018 load=1 shall take priority over en, shall write the loaded value in the next cycle, and shall clear the prescaler.
REQ-019 A load_units value greater than 9 shall be clamped to 9.
REQ-020 Vs shall be asserted for exactly one cycle, coincident with the first cycle in which bcd_units/bcd_tens hold a value that differs from the previous cycle.
REQ-021 Vs shall not be asserted when a load writes a value equal to the current value.
REQ-022 Carry shall pulse only on wrap, coincident with the wrapped value; it shall never pulse on load.
REQ-023 When PRESCALE=1, a tick shall occur on every enabled cycle.
REQ-024 When en is deasserted mid-prescale, the prescaler count shall be retained and counting shall resume from it.

Reset
REQ-025 With reset=1 at a clock edge, bcd_units=0, bcd_tens=0, prescaler=0, Vs=0 and carry=0 on the next cycle.
REQ-026 Reset shall take priority over load and en, including when asserted mid-prescale or mid-load.
REQ-027 Release of reset shall not generate a Vs or carry pulse.

Configuration
REQ-028 The macro SATURATE_EN, when defined, shall make counting saturate: up holds at 19, down holds at 00, carry stays 0, and no Vs is issued on a held tick.
REQ-029 When SATURATE_EN is undefined, the wrap behaviour of REQ-015/REQ-016 shall apply.

Verification
REQ-030 Scenario: reset, then en=1, up=1, PRESCALE=4 for 8 cycles -> value 02 after the 8th tick window; Vs pulses twice, 4 cycles apart.
REQ-031 Scenario: load 19 (load_units=9, load_tens=1), then one up step -> value 00 with carry=1 and Vs=1 in the same cycle.
REQ-032 Scenario: load 10, then one down step -> value 09 with Vs=1 and carry=0.
REQ-033 Scenario: load with load_units=12, load_tens=0 -> value 09; a repeated identical load produces no Vs.
REQ-034 Scenario: en=1 for 2 cycles, en=0 for 5 cycles, en=1 for 2 cycles at PRESCALE=4 -> exactly one step; load and en together -> load wins and the prescaler clears.
REQ-035 Scenario: reset asserted during load=1 and en=1 -> value 00, Vs=0, carry=0; with SATURATE_EN defined, 19 plus an up step -> stays 19, no Vs, no carry.
